// File: rtl/msu_audio_out_if.sv
`timescale 1ns/1ps
// Signals between the MSU audio output stage, the sample FIFO, the stream controller and the mixer.
// master = the audio output block; slave = its surroundings.
interface msu_audio_out_if;
    logic        audio_play;
    logic [7:0]  volume;
    logic [15:0] fifo_dout;
    logic [10:0] fifo_usedw;
    logic        fifo_rd;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_strobe;
    logic        underflow;

    modport master (
        input  audio_play, volume, fifo_dout, fifo_usedw,
        output fifo_rd, audio_l, audio_r, sample_strobe, underflow
    );

    modport slave (
        output audio_play, volume, fifo_dout, fifo_usedw,
        input  fifo_rd, audio_l, audio_r, sample_strobe, underflow
    );
endinterface

// File: rtl/msu_audio_out.sv
`timescale 1ns/1ps
// MSU-1 audio output: drift-free sample tick, stereo pair fetch from the FIFO,
// and volume scaling with a one-step-per-sample ramp.
module msu_audio_out #(
    parameter int unsigned CLK_HZ    = 21477272,
    parameter int unsigned SAMPLE_HZ = 44100
) (
    input  logic            clk,
    input  logic            reset,
    msu_audio_out_if.master bus
);
    typedef enum logic [1:0] {IDLE, CAP_L, CAP_R, SCALE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] acc_reg, acc_next;
    logic [32:0] acc_sum;
    logic        tick_reg, tick_next;
    logic [7:0]  cur_vol_reg, cur_vol_next, vol_target;
    logic [8:0]  gain;
    logic [15:0] raw_l_reg, raw_r_reg, r_src;
    logic        rd_tail_reg;
    logic [15:0] audio_l_reg, audio_r_reg;
    logic        fifo_rd_reg, fifo_rd_next;
    logic        underflow_reg, underflow_next;
    logic        strobe_reg, strobe_next;
    logic        pair_avail;

    // Fractional accumulator: the remainder carries over, so the tick rate has no long-term drift.
    always_comb begin
        acc_sum = {1'b0, acc_reg} + 33'(SAMPLE_HZ);
        if (acc_sum >= 33'(CLK_HZ)) begin
            acc_next  = 32'(acc_sum - 33'(CLK_HZ));
            tick_next = 1'b1;
        end else begin
            acc_next  = acc_sum[31:0];
            tick_next = 1'b0;
        end
    end

    always_comb begin
        vol_target   = bus.audio_play ? bus.volume : 8'd0;
        cur_vol_next = cur_vol_reg;
        if (tick_reg) begin
            if (cur_vol_reg < vol_target)
                cur_vol_next = cur_vol_reg + 8'd1;
            else if (cur_vol_reg > vol_target)
                cur_vol_next = cur_vol_reg - 8'd1;
        end
    end

    // 255 maps to 256 so full volume is an exact pass-through.
    assign gain = {1'b0, cur_vol_reg} + {8'd0, cur_vol_reg[7]};

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [8:0] g);
        logic signed [24:0] prod;
        prod = $signed({{9{s[15]}}, s}) * $signed({16'd0, g});
        return 16'(prod >>> 8);
    endfunction

    assign pair_avail = (bus.fifo_usedw >= 11'd2);

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick_reg) state_next = bus.audio_play && pair_avail ? CAP_L : SCALE;
            CAP_L:   state_next = CAP_R;
            CAP_R:   state_next = SCALE;
            SCALE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_next   = 1'b0;
        underflow_next = 1'b0;
        strobe_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tick_reg && bus.audio_play) begin
                    fifo_rd_next   = pair_avail;
                    underflow_next = !pair_avail;
                end
            end
            CAP_L:   fifo_rd_next = 1'b1;
            SCALE:   strobe_next  = 1'b1;
            default: ;
        endcase
    end

    // The FIFO is non-show-ahead: each word lands one cycle after its read strobe, so the
    // left word is on fifo_dout during CAP_R and the right word during SCALE.
    assign r_src = rd_tail_reg ? bus.fifo_dout : raw_r_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg       <= 32'd0;
            tick_reg      <= 1'b0;
            cur_vol_reg   <= 8'd0;
            raw_l_reg     <= 16'd0;
            raw_r_reg     <= 16'd0;
            rd_tail_reg   <= 1'b0;
            audio_l_reg   <= 16'd0;
            audio_r_reg   <= 16'd0;
            fifo_rd_reg   <= 1'b0;
            underflow_reg <= 1'b0;
            strobe_reg    <= 1'b0;
        end else begin
            acc_reg       <= acc_next;
            tick_reg      <= tick_next;
            cur_vol_reg   <= cur_vol_next;
            rd_tail_reg   <= (state_reg == CAP_R);
            fifo_rd_reg   <= fifo_rd_next;
            underflow_reg <= underflow_next;
            strobe_reg    <= strobe_next;
            if (state_reg == CAP_R)
                raw_l_reg <= bus.fifo_dout;
            if (state_reg == SCALE) begin
                raw_r_reg   <= r_src;
                audio_l_reg <= scale(raw_l_reg, gain);
                audio_r_reg <= scale(r_src, gain);
            end
        end
    end

    assign bus.fifo_rd       = fifo_rd_reg;
    assign bus.underflow     = underflow_reg;
    assign bus.sample_strobe = strobe_reg;
    assign bus.audio_l       = audio_l_reg;
    assign bus.audio_r       = audio_r_reg;
endmodule

// File: tb/tb_msu_audio_out.sv
`timescale 1ns/1ps
// Directed bench for msu_audio_out with a 10-cycle sample period and a pattern-fed FIFO model.
module tb_msu_audio_out;
    logic clk;
    logic reset;

    msu_audio_out_if bus();

    msu_audio_out #(
        .CLK_HZ(1000),
        .SAMPLE_HZ(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: alternating left/right pattern words, flushed together with the DUT.
    logic [15:0] pat_l, pat_r;
    int unsigned word_cnt;
    always @(posedge clk) begin
        if (reset) begin
            word_cnt      <= 0;
            bus.fifo_dout <= 16'h0000;
        end else if (bus.fifo_rd) begin
            bus.fifo_dout <= word_cnt[0] ? pat_r : pat_l;
            word_cnt      <= word_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc_n, rd_n, uf_n, uf_at, vol_m, first_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] scale(input logic [15:0] s, input int v);
        int g, p;
        g = v + ((v >= 128) ? 1 : 0);
        p = int'($signed(s)) * g;
        return 16'(p >>> 8);
    endfunction

    task automatic step();
        @(negedge clk);
        cyc_n++;
        if (bus.fifo_rd) rd_n++;
        if (bus.underflow) begin
            uf_n++;
            uf_at = cyc_n;
        end
    endtask

    // Each strobe corresponds to exactly one tick, so the expected volume steps once per call.
    task automatic wait_strobe();
        int tgt;
        tgt = bus.audio_play ? int'(bus.volume) : 0;
        if (vol_m < tgt) vol_m++;
        else if (vol_m > tgt) vol_m--;
        cyc_n = 0;
        rd_n  = 0;
        uf_n  = 0;
        uf_at = -1;
        do step(); while (!bus.sample_strobe && cyc_n < 40);
        check("strobe_seen", 32'(bus.sample_strobe), 32'd1);
        $display("t=%0t pair L=%04h R=%04h vol=%0d gap=%0d rd=%0d uf=%0d",
                 $time, bus.audio_l, bus.audio_r, vol_m, cyc_n, rd_n, uf_n);
    endtask

    task automatic run_pairs(input string ph, input int n, input logic [15:0] l,
                             input logic [15:0] r, input int exp_rd);
        for (int k = 0; k < n; k++) begin
            wait_strobe();
            check({ph, "_l"}, 32'(bus.audio_l), 32'(scale(l, vol_m)));
            check({ph, "_r"}, 32'(bus.audio_r), 32'(scale(r, vol_m)));
            check({ph, "_rd"}, rd_n, exp_rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.audio_play = 1'b0;
        bus.volume     = 8'd255;
        bus.fifo_usedw = 11'd1000;
        pat_l          = 16'h0000;
        pat_r          = 16'h0000;
        vol_m          = 0;
        repeat (3) @(negedge clk);
        check("rst_l", 32'(bus.audio_l), 32'h0);
        check("rst_r", 32'(bus.audio_r), 32'h0);
        check("rst_rd", 32'(bus.fifo_rd), 32'h0);
        check("rst_strobe", 32'(bus.sample_strobe), 32'h0);
        check("rst_uf", 32'(bus.underflow), 32'h0);
        reset = 1'b0;

        // Cadence while paused: tick after 10 cycles, strobe 2 cycles later, then every 10.
        wait_strobe();
        check("idle_first_gap", cyc_n, 12);
        for (int k = 0; k < 5; k++) begin
            wait_strobe();
            check("idle_gap", cyc_n, 10);
            check("idle_rd", rd_n, 0);
            check("idle_l", 32'(bus.audio_l), 32'h0);
            check("idle_r", 32'(bus.audio_r), 32'h0);
        end

        // Ramp up to unity.
        pat_l          = 16'h4000;
        pat_r          = 16'hC000;
        bus.audio_play = 1'b1;
        run_pairs("ramp", 255, 16'h4000, 16'hC000, 2);
        check("unity_l", 32'(bus.audio_l), 32'h4000);
        check("unity_r", 32'(bus.audio_r), 32'hC000);
        check("read_gap", cyc_n, 10);

        // Ramp down to 64 and check scaling there.
        bus.volume = 8'd64;
        run_pairs("down", 191, 16'h4000, 16'hC000, 2);
        check("vol64_l", 32'(bus.audio_l), 32'h1000);
        check("vol64_r", 32'(bus.audio_r), 32'hF000);
        pat_l = 16'hFFFD;
        pat_r = 16'h8000;
        run_pairs("neg", 1, 16'hFFFD, 16'h8000, 2);
        check("neg_l", 32'(bus.audio_l), 32'hFFFF);
        check("neg_r", 32'(bus.audio_r), 32'hE000);

        // Underflow: one word only, previous pair repeats, strobe 2 cycles after the tick.
        bus.fifo_usedw = 11'd1;
        wait_strobe();
        check("uf_gap", cyc_n, 8);
        check("uf_rd", rd_n, 0);
        check("uf_count", uf_n, 1);
        check("uf_pos", uf_at, cyc_n - 1);
        check("uf_l", 32'(bus.audio_l), 32'hFFFF);
        check("uf_r", 32'(bus.audio_r), 32'hE000);

        // Exactly two words available is enough for a pair.
        bus.fifo_usedw = 11'd2;
        run_pairs("usedw2", 1, 16'hFFFD, 16'h8000, 2);
        check("usedw2_gap", cyc_n, 12);
        check("usedw2_uf", uf_n, 0);

        // Back to unity, then pause and fade out on held samples.
        bus.fifo_usedw = 11'd1000;
        pat_l          = 16'h4000;
        pat_r          = 16'hC000;
        bus.volume     = 8'd255;
        run_pairs("up", 191, 16'h4000, 16'hC000, 2);
        bus.audio_play = 1'b0;
        run_pairs("pause", 255, 16'h4000, 16'hC000, 0);
        check("paused_l", 32'(bus.audio_l), 32'h0);
        check("paused_r", 32'(bus.audio_r), 32'h0);
        bus.audio_play = 1'b1;
        run_pairs("resume", 1, 16'h4000, 16'hC000, 2);
        check("resume_l", 32'(bus.audio_l), 32'h0040);
        check("resume_r", 32'(bus.audio_r), 32'hFFC0);

        // Reset during CAP_L (first cycle fifo_rd is high).
        cyc_n = 0;
        rd_n  = 0;
        do step(); while (!bus.fifo_rd && cyc_n < 20);
        check("caprst_rd_seen", 32'(bus.fifo_rd), 32'd1);
        reset = 1'b1;
        step();
        check("caprst_rd", 32'(bus.fifo_rd), 32'h0);
        check("caprst_l", 32'(bus.audio_l), 32'h0);
        check("caprst_r", 32'(bus.audio_r), 32'h0);
        check("caprst_strobe", 32'(bus.sample_strobe), 32'h0);
        check("caprst_uf", 32'(bus.underflow), 32'h0);
        reset    = 1'b0;
        cyc_n    = 0;
        rd_n     = 0;
        first_rd = -1;
        do begin
            step();
            if (bus.fifo_rd && first_rd < 0) first_rd = cyc_n;
        end while (!bus.sample_strobe && cyc_n < 40);
        $display("t=%0t pair L=%04h R=%04h after reset first_rd=%0d gap=%0d rd=%0d",
                 $time, bus.audio_l, bus.audio_r, first_rd, cyc_n, rd_n);
        check("post_rst_first_rd", first_rd, 11);
        check("post_rst_strobe", cyc_n, 14);
        check("post_rst_rd", rd_n, 2);
        check("post_rst_l", 32'(bus.audio_l), 32'h0040);
        check("post_rst_r", 32'(bus.audio_r), 32'hFFC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
